// File: rtl/alu_seq_responder.sv
// -----------------------------------------------------------------------------
// alu_seq_responder
//
// Sequential ALU that responds to an instruction-word interface. It accepts one
// instruction per in_valid/in_ready handshake and returns a 64-bit result plus
// an error flag over an out_valid/out_ready handshake.
//   add / sub / sl / sr / invalid : result registered at the accept edge
//   mul                           : 32-cycle shift-add on operand magnitudes
//   div                           : 32-cycle restoring division on magnitudes
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   in_valid     in   1   instruction present on in_opr* inputs
//   in_ready     out  1   instruction can be accepted (state IDLE)
//   in_opr       in   3   0 add, 1 sub, 2 mul, 3 div, 4 sl, 5 sr, 6/7 invalid
//   in_opr_type  in   1   0 signed, 1 unsigned
//   in_opr_a     in   32  operand A
//   in_opr_b     in   32  operand B
//   out_valid    out  1   result/err valid, held until consumed
//   out_ready    in   1   consumer accepts the result
//   out_result   out  64  result word (div: {remainder, quotient})
//   out_err      out  1   invalid opcode or divide by zero
//   busy         out  1   iterative operation in progress (state EXEC)
// -----------------------------------------------------------------------------
module alu_seq_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_opr,
    input  logic        in_opr_type,
    input  logic [31:0] in_opr_a,
    input  logic [31:0] in_opr_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic        out_err,
    output logic        busy
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_SL  = 3'd4;
    localparam logic [2:0] OP_SR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Sign- or zero-extend a 32-bit operand to 64 bits.
    function automatic logic [63:0] ext64(input logic [31:0] x, input logic is_unsigned);
        ext64 = is_unsigned ? {32'd0, x} : {{32{x[31]}}, x};
    endfunction

    // Magnitude of an operand; 0x8000_0000 maps to itself, which is correct
    // when the magnitude is treated as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        mag32 = (is_signed && x[31]) ? (32'd0 - x) : x;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;     // negate product / quotient at the end
    logic        r_neg_r;     // negate remainder at the end
    logic        r_dz;        // divide by zero
    logic [31:0] r_a;         // raw operand A, returned as remainder on divide by zero

    // multiply datapath
    logic [63:0] r_acc;
    logic [63:0] r_mcd;
    logic [31:0] r_mpl;

    // divide datapath
    logic [31:0] r_quo;       // dividend bits shift out as quotient bits shift in
    logic [31:0] r_rem;
    logic [31:0] r_dvs;

    logic        r_out_valid;
    logic [63:0] r_out_result;
    logic        r_out_err;

    logic        w_accept;
    logic        w_is_iter;
    logic        w_last;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_single_res;
    logic        w_single_err;
    logic [63:0] w_mul_acc_nxt;
    logic [63:0] w_mul_fin;
    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_div_rem_nxt;
    logic [31:0] w_div_quo_nxt;
    logic [31:0] w_quo_fin;
    logic [31:0] w_rem_fin;
    logic [63:0] w_div_fin;

    assign in_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_EXEC);
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_err    = r_out_err;

    assign w_accept  = in_valid & in_ready;
    assign w_is_iter = (in_opr == OP_MUL) || (in_opr == OP_DIV);
    assign w_last    = (r_cnt == 5'd31);
    assign w_ext_a   = ext64(in_opr_a, in_opr_type);
    assign w_ext_b   = ext64(in_opr_b, in_opr_type);

    // Results of the single-cycle operations, taken straight from the inputs.
    always_comb begin
        w_single_res = 64'd0;
        w_single_err = 1'b0;
        case (in_opr)
            OP_ADD: w_single_res = w_ext_a + w_ext_b;
            OP_SUB: w_single_res = w_ext_a - w_ext_b;
            OP_SL:  w_single_res = w_ext_a << in_opr_b[4:0];
            OP_SR: begin
                if (in_opr_type) begin
                    w_single_res = w_ext_a >> in_opr_b[4:0];
                end else begin
                    w_single_res = $signed(w_ext_a) >>> in_opr_b[4:0];
                end
            end
            OP_MUL, OP_DIV: w_single_res = 64'd0;
            default: begin
                w_single_res = 64'd0;
                w_single_err = 1'b1;
            end
        endcase
    end

    // One shift-add step and one restoring-division step, plus sign fix-up.
    always_comb begin
        w_mul_acc_nxt = r_acc + (r_mpl[0] ? r_mcd : 64'd0);
        w_mul_fin     = r_neg_q ? (64'd0 - w_mul_acc_nxt) : w_mul_acc_nxt;
        // partial remainder is below the divisor, so the shifted value fits 33 bits
        w_div_shift   = {r_rem, r_quo[31]};
        w_div_ge      = (w_div_shift >= {1'b0, r_dvs});
        w_div_rem_nxt = w_div_ge ? (w_div_shift[31:0] - r_dvs) : w_div_shift[31:0];
        w_div_quo_nxt = {r_quo[30:0], w_div_ge};
        w_quo_fin     = r_neg_q ? (32'd0 - w_div_quo_nxt) : w_div_quo_nxt;
        w_rem_fin     = r_neg_r ? (32'd0 - w_div_rem_nxt) : w_div_rem_nxt;
        if (r_dz) begin
            w_div_fin = {r_a, 32'hFFFF_FFFF};
        end else begin
            w_div_fin = {w_rem_fin, w_quo_fin};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_iter ? ST_EXEC : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 5'd0;
            r_is_div     <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_dz         <= 1'b0;
            r_a          <= 32'd0;
            r_acc        <= 64'd0;
            r_mcd        <= 64'd0;
            r_mpl        <= 32'd0;
            r_quo        <= 32'd0;
            r_rem        <= 32'd0;
            r_dvs        <= 32'd0;
            r_out_valid  <= 1'b0;
            r_out_result <= 64'd0;
            r_out_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_div <= (in_opr == OP_DIV);
                        r_neg_q  <= ~in_opr_type & (in_opr_a[31] ^ in_opr_b[31]);
                        r_neg_r  <= ~in_opr_type & in_opr_a[31];
                        r_dz     <= (in_opr_b == 32'd0);
                        r_a      <= in_opr_a;
                        r_cnt    <= 5'd0;
                        r_acc    <= 64'd0;
                        r_mcd    <= {32'd0, mag32(in_opr_a, ~in_opr_type)};
                        r_mpl    <= mag32(in_opr_b, ~in_opr_type);
                        r_quo    <= mag32(in_opr_a, ~in_opr_type);
                        r_rem    <= 32'd0;
                        r_dvs    <= mag32(in_opr_b, ~in_opr_type);
                        if (!w_is_iter) begin
                            r_out_valid  <= 1'b1;
                            r_out_result <= w_single_res;
                            r_out_err    <= w_single_err;
                        end
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt + 5'd1;
                    r_acc <= w_mul_acc_nxt;
                    r_mcd <= {r_mcd[62:0], 1'b0};
                    r_mpl <= {1'b0, r_mpl[31:1]};
                    r_quo <= w_div_quo_nxt;
                    r_rem <= w_div_rem_nxt;
                    if (w_last) begin
                        r_out_valid  <= 1'b1;
                        r_out_result <= r_is_div ? w_div_fin : w_mul_fin;
                        r_out_err    <= r_is_div & r_dz;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_responder.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_responder
//
// Directed-vector bench for alu_seq_responder. A cycle-level reference model
// (expected outputs computed with plain integer arithmetic) is checked against
// the DUT on every cycle; each directed vector also carries hand-computed
// literal expectations for result, error, latency and busy duration.
// -----------------------------------------------------------------------------
module tb_alu_seq_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opr;
    logic        in_opr_type;
    logic [31:0] in_opr_a;
    logic [31:0] in_opr_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_err;
    logic        busy;

    always #5 clk = ~clk;

    alu_seq_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opr      (in_opr),
        .in_opr_type (in_opr_type),
        .in_opr_a    (in_opr_a),
        .in_opr_b    (in_opr_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_err     (out_err),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int          cyc = 0;
    bit          pend = 1'b0;
    logic [64:0] p_exp = 65'd0;
    int          p_acc = 0;
    int          p_lat = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected {err, result} straight from the arithmetic definition of each op.
    function automatic logic [64:0] mdl(input logic [2:0] op, input logic uns,
                                        input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          st;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ut;
        longint          q;
        longint          r;
        logic [63:0]     ea;
        logic [63:0]     eb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ea = uns ? ua : sa;
        eb = uns ? ub : sb;
        case (op)
            3'd0: mdl = {1'b0, ea + eb};
            3'd1: mdl = {1'b0, ea - eb};
            3'd2: begin
                st = sa * sb;
                ut = ua * ub;
                mdl = uns ? {1'b0, ut} : {1'b0, st};
            end
            3'd3: begin
                if (b == 32'd0) begin
                    mdl = {1'b1, a, 32'hFFFF_FFFF};
                end else if (uns) begin
                    ut = ua / ub;
                    st = longint'(ua % ub);
                    mdl = {1'b0, st[31:0], ut[31:0]};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    mdl = {1'b0, r[31:0], q[31:0]};
                end
            end
            3'd4: mdl = {1'b0, ea << b[4:0]};
            3'd5: begin
                st = longint'(ea);
                st = st >>> b[4:0];
                mdl = uns ? {1'b0, ea >> b[4:0]} : {1'b0, st};
            end
            default: mdl = {1'b1, 64'd0};
        endcase
    endfunction

    // Model of the handshake timeline: accept, completion cycle, consumption.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else if (pend) begin
            if ((cyc >= p_acc + p_lat - 1) && out_ready) pend = 1'b0;
        end else if (in_valid) begin
            pend  = 1'b1;
            p_exp = mdl(in_opr, in_opr_type, in_opr_a, in_opr_b);
            p_acc = cyc + 1;
            p_lat = (in_opr == 3'd2 || in_opr == 3'd3) ? 33 : 1;
        end
        cyc = cyc + 1;
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        bit ev;
        bit eb;
        #1;
        if (!rst_n) begin
            chk("rst in_ready", 64'(in_ready), 64'd1);
            chk("rst busy", 64'(busy), 64'd0);
            chk("rst out_valid", 64'(out_valid), 64'd0);
            chk("rst out_result", out_result, 64'd0);
            chk("rst out_err", 64'(out_err), 64'd0);
        end else begin
            ev = pend && (cyc >= p_acc + p_lat - 1);
            eb = pend && (p_lat == 33) && !ev;
            chk("cyc in_ready", 64'(in_ready), 64'(!pend));
            chk("cyc busy", 64'(busy), 64'(eb));
            chk("cyc out_valid", 64'(out_valid), 64'(ev));
            if (ev) begin
                chk("cyc out_result", out_result, p_exp[63:0]);
                chk("cyc out_err", 64'(out_err), 64'(p_exp[64]));
            end
        end
    end

    // Issue one instruction, wait for its result, check literals, consume it.
    task automatic run(input string nm, input logic [2:0] op, input logic uns,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] er, input logic ee,
                       input int hold, input bit early);
        logic [64:0] m;
        int w;
        int lat;
        int nb;
        int exp_lat;
        m = mdl(op, uns, a, b);
        chk({nm, " model result"}, m[63:0], er);
        chk({nm, " model err"}, 64'(m[64]), 64'(ee));
        exp_lat = (op == 3'd2 || op == 3'd3) ? 33 : 1;
        @(negedge clk);
        in_valid = 1'b1; in_opr = op; in_opr_type = uns; in_opr_a = a; in_opr_b = b;
        out_ready = early;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk({nm, " accept timeout"}, 64'd0, 64'd1);
            in_valid = 1'b0;
            out_ready = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 0;
        nb = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                // later input changes must not affect the accepted instruction
                in_valid = 1'b0; in_opr = 3'd1; in_opr_type = ~uns;
                in_opr_a = ~a; in_opr_b = b ^ 32'h0000_0013;
            end
            if (busy) nb++;
        end while (!out_valid && lat < 60);
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " busy cycles"}, 64'(nb), 64'((exp_lat == 33) ? 32 : 0));
        if (!early) begin
            repeat (hold) @(negedge clk);
        end
        chk({nm, " result"}, out_result, er);
        chk({nm, " err"}, 64'(out_err), 64'(ee));
        chk({nm, " in_ready while done"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk({nm, " out_valid after consume"}, 64'(out_valid), 64'd0);
        chk({nm, " in_ready after consume"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opr = 3'd0; in_opr_type = 1'b0; in_opr_a = 32'd0; in_opr_b = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run("add s",    3'd0, 1'b0, 32'h0000_0010, 32'h0000_0020, 64'h0000_0000_0000_0030, 1'b0, 5, 1'b0);
        run("sub s",    3'd1, 1'b0, 32'h0000_0010, 32'h0000_0020, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 0, 1'b0);
        run("sub u",    3'd1, 1'b1, 32'h0000_0010, 32'h0000_0020, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1, 1'b0);
        run("add u",    3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0001_0000_0000, 1'b0, 0, 1'b0);
        run("add s wr", 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_0000_0000, 1'b0, 0, 1'b0);
        run("mul s",    3'd2, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 2, 1'b0);
        run("mul u",    3'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 0, 1'b1);
        run("mul s min",3'd2, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 0, 1'b0);
        run("div s",    3'd3, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0, 1'b0);
        run("div s nn", 3'd3, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003, 1'b0, 0, 1'b0);
        run("div u dz", 3'd3, 1'b1, 32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF, 1'b1, 3, 1'b0);
        run("div s dz", 3'd3, 1'b0, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF, 1'b1, 0, 1'b0);
        run("div s ovf",3'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 0, 1'b0);
        run("div u",    3'd3, 1'b1, 32'hFFFF_FFF9, 32'h0000_0010, 64'h0000_0009_0FFF_FFFF, 1'b0, 0, 1'b0);
        run("sr s",     3'd5, 1'b0, 32'h8000_0000, 32'h0000_0004, 64'hFFFF_FFFF_F800_0000, 1'b0, 0, 1'b0);
        run("sr u",     3'd5, 1'b1, 32'h8000_0000, 32'h0000_0004, 64'h0000_0000_0800_0000, 1'b0, 0, 1'b0);
        run("sl",       3'd4, 1'b0, 32'h0000_0001, 32'h0000_0025, 64'h0000_0000_0000_0020, 1'b0, 0, 1'b0);
        run("sl s neg", 3'd4, 1'b0, 32'hFFFF_FFFF, 32'h0000_001F, 64'hFFFF_FFFF_8000_0000, 1'b0, 0, 1'b1);
        run("op7",      3'd7, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0000_0000_0000_0000, 1'b1, 0, 1'b0);
        run("op6",      3'd6, 1'b1, 32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0000, 1'b1, 0, 1'b0);

        // abort a multiply with reset while a second instruction is presented
        @(negedge clk);
        in_valid = 1'b1; in_opr = 3'd2; in_opr_type = 1'b0;
        in_opr_a = 32'h0000_0005; in_opr_b = 32'h0000_0007;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_opr = 3'd0; in_opr_a = 32'h0000_0001; in_opr_b = 32'h0000_0002;
        repeat (9) @(negedge clk);
        #1;
        chk("abort busy before reset", 64'(busy), 64'd1);
        chk("abort in_ready before reset", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort out_result", out_result, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run("add after abort", 3'd0, 1'b0, 32'h0000_0003, 32'h0000_0004, 64'h0000_0000_0000_0007, 1'b0, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_responder.md
# alu_seq_responder

Sequential ALU that is the responder for the instruction-word interface the ALU benches drive: it accepts one instruction (opcode, operand type, two 32-bit operands) per valid/ready handshake, executes it, and returns a 64-bit result plus error flag over a second valid/ready handshake. Add, sub and shifts complete in one cycle. Mul and div are iterative, 32 cycles each. It sits between an instruction issuer (bench or sequencer) and a result consumer.

## Interface
- No parameters; operand width is fixed at 32 bits and result width at 64 bits.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present on in_opr/in_opr_type/in_opr_a/in_opr_b.
- in_ready  out  1  block can accept an instruction; high only in IDLE.
- in_opr  in  3  opcode: add=0, sub=1, mul=2, div=3, sl=4, sr=5; 6 and 7 are invalid.
- in_opr_type  in  1  0 = sign, 1 = unsign.
- in_opr_a  in  32  operand A.
- in_opr_b  in  32  operand B.
- out_valid  out  1  result/err valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- out_result  out  64  result word.
- out_err  out  1  invalid opcode or divide-by-zero.
- busy  out  1  high in EXEC.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE -> DONE on accept (in_valid & in_ready) for add/sub/sl/sr/invalid.
  - IDLE -> EXEC on accept for mul/div.
  - EXEC -> DONE when the iteration counter reaches 31.
  - DONE -> IDLE on out_valid & out_ready.
- Operands, opcode and type are registered at accept. Input changes afterwards have no effect.
- ext64(x): sign-extend if sign, zero-extend if unsign.
- add: ext64(a) + ext64(b).
- sub: ext64(a) − ext64(b), two's complement modulo 2^64.
- mul: full 64-bit product, signed or unsigned.
  - Shift-add on magnitudes, one bit per EXEC cycle.
  - Final negate when signed and the operand signs differ.
- div: restoring division on magnitudes, one bit per cycle.
  - out_result[31:0] = quotient; out_result[63:32] = remainder.
  - Signed quotient truncates toward zero. Signed remainder takes the sign of the dividend.
  - Signed 0x8000_0000 / 0xFFFF_FFFF: quotient 0x8000_0000, remainder 0, err 0.
  - Divide by zero: quotient 0xFFFF_FFFF, remainder = a, err 1. Still takes the full 32 cycles.
- sl: ext64(a) << b[4:0].
- sr: ext64(a) >> b[4:0]; arithmetic when sign, logical when unsign. b[31:5] is ignored.
- Invalid opcode (6, 7): result 0, err 1.
- out_err is 0 for all other cases.

## Timing
- Reset values:
  - State IDLE; in_ready 1; busy 0.
  - out_valid 0; out_result 0; out_err 0.
  - Iteration counter 0; all datapath registers 0.
- in_ready = (state == IDLE), combinational from state. It is 1 while rst_n is low.
- Accept at edge T:
  - Single-cycle ops: out_valid high from T+1.
  - mul/div: busy high T+1..T+32; out_valid high from T+33.
- out_result and out_err are registered. They are stable for the whole time out_valid is high.
- out_valid deasserts on the edge where out_valid & out_ready is sampled.
- in_ready returns high in the cycle after that edge. Back-to-back throughput is therefore one instruction per 2 cycles (single-cycle ops).
- out_ready high before out_valid rises has no effect. out_ready is only sampled in DONE.
- in_valid while not IDLE is ignored. No instruction is queued; the issuer must hold in_valid until accepted.
- Asynchronous reset in EXEC or DONE:
  - Aborts immediately; the pending result is lost.
  - All outputs return to reset values.
  - No out_valid is produced for the aborted instruction.
- Deasserting rst_n takes effect at the next rising edge; the block can accept on the first edge after release.

## Test plan
- Reset, then signed add a=0x10, b=0x20 -> out_valid 1 cycle after accept, out_result 0x30, err 0; with out_ready held low for 5 cycles, result stays stable and in_ready stays 0.
- Signed sub a=0x10, b=0x20 -> 0xFFFF_FFFF_FFFF_FFF0. Unsigned sub with the same operands -> 0xFFFF_FFFF_FFFF_FFF0 (mod 2^64), err 0.
- Signed mul a=0xFFFF_FFFE (−2), b=3 -> 0xFFFF_FFFF_FFFF_FFFA. Unsigned mul a=b=0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001. Both with out_valid exactly 33 cycles after accept and busy high for 32 cycles.
- Signed div −7/2 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. Unsigned div 7/0 -> out_result 0x0000_0007_FFFF_FFFF, err 1. Signed 0x8000_0000 / −1 -> 0x0000_0000_8000_0000, err 0.
- Shifts:
  - Signed sr a=0x8000_0000, b=4 -> 0xFFFF_FFFF_F800_0000.
  - Unsigned sr same operands -> 0x0000_0000_0800_0000.
  - sl a=1, b=0x25 (shift 5) -> 0x20.
  - Opcode 7 -> result 0, err 1.
- Pull rst_n low 10 cycles into a mul, with in_valid asserted while busy -> the busy-period instruction is never accepted; outputs go to reset values immediately; no out_valid for the aborted mul; the next add is accepted and completes normally.
